bullet_collision_scanner: RTL and testbench
===========================================

BULLET_COLLISION_SCANNER -- requirements
Module: bullet_collision_scanner

Interface
REQ-001 SHALL have parameter HP_MAX, default 20: reset and maximum HP value.
REQ-002 SHALL have parameter DAMAGE, default 1: HP lost per damaging hit.
REQ-003 SHALL have parameter HEAL, default 1: HP gained per green hit.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse requesting a scan of all 8 bullet slots.
REQ-007 player_pos  input  16  [15:8] player x, [7:0] player y.
REQ-008 player_size  input  16  [15:8] player width, [7:0] player height.
REQ-009 player_moving  input  1  player moved this frame; used for blue bullets.
REQ-010 bullet_index  output  3  slot address driven to the bullet table read/clear port.
REQ-011 bullet_pos  input  16  [15:8] x, [7:0] y of the addressed slot, combinational from bullet_index.
REQ-012 bullet_size  input  16  [15:8] width, [7:0] height of the addressed slot.
REQ-013 bullet_color  input  3  000 white, 001 green, 010 blue; other codes are inert.
REQ-014 bullet_render  input  1  slot active.
REQ-015 is_collide  output  1  one-cycle pulse; bullet table clears render bit of slot bullet_index.
REQ-016 hp  output  8  current player HP.
REQ-017 dead  output  1  high while hp == 0.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 done  output  1  one-cycle pulse at scan completion.

Function
REQ-020 SHALL implement FSM states IDLE, SCAN, HIT, DONE.
REQ-021 IDLE: on start=1, SHALL go to SCAN with bullet_index=0; otherwise hold.
REQ-022 SCAN: SHALL evaluate the addressed slot combinationally in one cycle. On a hit, it SHALL latch the color and go to HIT with bullet_index held. On a miss at index 7, it SHALL go to DONE. On any other miss, it SHALL increment bullet_index and stay in SCAN.
REQ-023 Hit condition SHALL be bullet_render=1 AND strict axis-aligned box overlap: px < bx+bw, bx < px+pw, py < by+bh, by < py+ph.
REQ-024 Each sum in the hit condition SHALL be computed 9 bits wide with no 8-bit wrap; zero width or height SHALL never overlap.
REQ-025 HIT: SHALL assert is_collide for exactly that cycle and apply the HP effect of the latched color. It SHALL then go to DONE if index was 7, else to SCAN with index+1.
REQ-026 HP effects: white subtracts DAMAGE; blue subtracts DAMAGE only if player_moving=1 (sampled in HIT); green adds HEAL; other codes leave hp unchanged.
REQ-027 Blue with player_moving=0 and other color codes SHALL still pulse is_collide.
REQ-028 Subtraction SHALL saturate at 0; addition SHALL saturate at HP_MAX.
REQ-029 DONE: SHALL assert done for one cycle, set bullet_index=0, and return to IDLE.
REQ-030 Scan latency SHALL be 8 + (number of hits) + 1 cycles from the cycle after start to done, inclusive.
REQ-031 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-032 When hp=0, scanning SHALL continue, damage SHALL have no effect, and green SHALL still heal.
REQ-033 bullet_index SHALL be 0 whenever in IDLE.
REQ-034 is_collide and done SHALL never be high in the same cycle.

Reset
REQ-035 rst=1 SHALL asynchronously force state=IDLE, bullet_index=0, is_collide=0, done=0, busy=0, hp=HP_MAX, dead=0.
REQ-036 rst asserted mid-scan SHALL abort the scan with no is_collide or done pulse. After release, the block SHALL wait for a new start.

Verification
REQ-037 Player (50,50) size (16,16); all slots render=0; start -> done 9 cycles later, is_collide never high, hp=20.
REQ-038 Slot 3 white at (60,60) size (8,8), render=1; start -> single is_collide with bullet_index=3; hp 20->19; done on cycle 10.
REQ-039 Slot 5 blue overlapping: player_moving=0 -> pulse, hp unchanged; player_moving=1 -> hp decreases by 1.
REQ-040 Boundary: bullet at x=66 with px=50, pw=16 (touching edge) -> no hit. Bullet at (250,250) size (10,10) with player (245,245) size (8,8) -> hit; no wrap.
REQ-041 hp=1 with white hits in slots 0 and 1 -> hp=0 and dead=1; a green hit in slot 2 -> hp=1. hp=20 with a green hit -> hp stays 20.
REQ-042 rst pulsed during HIT at slot 2 -> is_collide low, hp=20, idle. start is ignored while busy -> exactly one done per accepted start.

Source files
------------

// File: rtl/bullet_collision_scanner.sv
// Walks the 8-slot bullet table once per start pulse, flags each overlapping
// bullet for clearing and applies its colour's HP effect to the player.
module bullet_collision_scanner #(
  parameter int HP_MAX = 20,
  parameter int DAMAGE = 1,
  parameter int HEAL   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] player_pos,
  input  logic [15:0] player_size,
  input  logic        player_moving,
  output logic [2:0]  bullet_index,
  input  logic [15:0] bullet_pos,
  input  logic [15:0] bullet_size,
  input  logic [2:0]  bullet_color,
  input  logic        bullet_render,
  output logic        is_collide,
  output logic [7:0]  hp,
  output logic        dead,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SCAN, HIT, DONE} state_t;

  localparam logic [9:0] DMG10 = 10'(DAMAGE);
  localparam logic [9:0] HEAL10 = 10'(HEAL);
  localparam logic [9:0] MAX10 = 10'(HP_MAX);

  state_t     state;
  logic [2:0] color_q;

  logic [8:0] px, py, pw, ph, bx, by, bw, bh;
  logic       sizes_ok;
  logic       hit;

  // Nine-bit operands keep x+w from wrapping past the right/bottom edge.
  assign px = {1'b0, player_pos[15:8]};
  assign py = {1'b0, player_pos[7:0]};
  assign pw = {1'b0, player_size[15:8]};
  assign ph = {1'b0, player_size[7:0]};
  assign bx = {1'b0, bullet_pos[15:8]};
  assign by = {1'b0, bullet_pos[7:0]};
  assign bw = {1'b0, bullet_size[15:8]};
  assign bh = {1'b0, bullet_size[7:0]};

  assign sizes_ok = (|pw) && (|ph) && (|bw) && (|bh);
  assign hit = bullet_render && sizes_ok &&
               (px < bx + bw) && (bx < px + pw) &&
               (py < by + bh) && (by < py + ph);

  logic [9:0] hp_sum;
  logic [7:0] hp_dec;
  logic [7:0] hp_inc;
  logic [7:0] hp_after;

  always_comb begin
    hp_sum   = {2'b00, hp} + HEAL10;
    hp_dec   = ({2'b00, hp} > DMG10) ? 8'({2'b00, hp} - DMG10) : 8'd0;
    hp_inc   = (hp_sum >= MAX10) ? 8'(HP_MAX) : hp_sum[7:0];
    hp_after = hp;
    case (color_q)
      3'b000:  hp_after = hp_dec;
      3'b001:  hp_after = hp_inc;
      3'b010:  hp_after = player_moving ? hp_dec : hp;
      default: hp_after = hp;
    endcase
  end

  assign dead = (hp == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bullet_index <= 3'd0;
      color_q      <= 3'd0;
      is_collide   <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      hp           <= 8'(HP_MAX);
    end else begin
      is_collide <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          bullet_index <= 3'd0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (hit) begin
            color_q    <= bullet_color;
            is_collide <= 1'b1;
            state      <= HIT;
          end else if (bullet_index == 3'd7) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bullet_index <= bullet_index + 3'd1;
          end
        end
        HIT: begin
          hp <= hp_after;
          if (bullet_index == 3'd7) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bullet_index <= bullet_index + 3'd1;
            state        <= SCAN;
          end
        end
        DONE: begin
          bullet_index <= 3'd0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// Directed and randomized scans of bullet_collision_scanner against a
// geometric interval-overlap model of the bullet table and player HP.
module tb_bullet_collision_scanner;
  localparam int HP_MAX = 20;
  localparam int DAMAGE = 1;
  localparam int HEAL   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] player_pos;
  logic [15:0] player_size;
  logic        player_moving;
  logic [2:0]  bullet_index;
  logic [15:0] bullet_pos;
  logic [15:0] bullet_size;
  logic [2:0]  bullet_color;
  logic        bullet_render;
  logic        is_collide;
  logic [7:0]  hp;
  logic        dead;
  logic        busy;
  logic        done;

  logic [7:0] b_x [8];
  logic [7:0] b_y [8];
  logic [7:0] b_w [8];
  logic [7:0] b_h [8];
  logic [2:0] b_col [8];
  logic       b_ren [8];

  assign bullet_pos    = {b_x[bullet_index], b_y[bullet_index]};
  assign bullet_size   = {b_w[bullet_index], b_h[bullet_index]};
  assign bullet_color  = b_col[bullet_index];
  assign bullet_render = b_ren[bullet_index];

  bullet_collision_scanner #(.HP_MAX(HP_MAX), .DAMAGE(DAMAGE), .HEAL(HEAL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .player_pos(player_pos), .player_size(player_size), .player_moving(player_moving),
    .bullet_index(bullet_index), .bullet_pos(bullet_pos), .bullet_size(bullet_size),
    .bullet_color(bullet_color), .bullet_render(bullet_render),
    .is_collide(is_collide), .hp(hp), .dead(dead), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hp_m;
  int exp_idx[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Two half-open intervals intersect iff the later start precedes the earlier end.
  function automatic bit spans_meet(input int a, input int aw, input int c, input int cw);
    int lo, hi;
    lo = (a > c) ? a : c;
    hi = ((a + aw) < (c + cw)) ? (a + aw) : (c + cw);
    return lo < hi;
  endfunction

  task automatic model_scan();
    int px, py, pw, ph;
    px = int'(player_pos[15:8]);  py = int'(player_pos[7:0]);
    pw = int'(player_size[15:8]); ph = int'(player_size[7:0]);
    exp_idx.delete();
    for (int i = 0; i < 8; i++) begin
      if (b_ren[i] && spans_meet(px, pw, int'(b_x[i]), int'(b_w[i]))
                   && spans_meet(py, ph, int'(b_y[i]), int'(b_h[i]))) begin
        exp_idx.push_back(i);
        if (b_col[i] == 3'd0 || (b_col[i] == 3'd2 && player_moving))
          hp_m = (hp_m - DAMAGE < 0) ? 0 : hp_m - DAMAGE;
        else if (b_col[i] == 3'd1)
          hp_m = (hp_m + HEAL > HP_MAX) ? HP_MAX : hp_m + HEAL;
      end
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 8; i++) begin
      b_x[i] = 8'd0; b_y[i] = 8'd0; b_w[i] = 8'd0; b_h[i] = 8'd0;
      b_col[i] = 3'd0; b_ren[i] = 1'b0;
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int w, input int h,
                          input int col);
    b_x[i] = 8'(x); b_y[i] = 8'(y); b_w[i] = 8'(w); b_h[i] = 8'(h);
    b_col[i] = 3'(col); b_ren[i] = 1'b1;
  endtask

  task automatic set_player(input int x, input int y, input int w, input int h, input bit mv);
    player_pos    = {8'(x), 8'(y)};
    player_size   = {8'(w), 8'(h)};
    player_moving = mv;
  endtask

  task automatic run_scan(input string tag, input int busy_start_at, input bit start_in_done);
    int  got_idx[$];
    int  cyc, both, busy_low, n;
    bit  seen_done;
    model_scan();
    @(negedge clk); start = 1'b1;
    cyc = 0; seen_done = 1'b0; both = 0; busy_low = 0;
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == busy_start_at);
      if (is_collide) got_idx.push_back(int'(bullet_index));
      if (is_collide && done) both++;
      if (!busy) busy_low++;
      if (done) seen_done = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, int'(seen_done), 1);
    chk({tag, "_latency"}, cyc, 9 + exp_idx.size());
    chk({tag, "_hits"}, got_idx.size(), exp_idx.size());
    n = (got_idx.size() < exp_idx.size()) ? got_idx.size() : exp_idx.size();
    for (int i = 0; i < n; i++) chk({tag, "_hit_index"}, got_idx[i], exp_idx[i]);
    chk({tag, "_collide_with_done"}, both, 0);
    chk({tag, "_busy_drop"}, busy_low, 0);
    chk({tag, "_hp"}, int'(hp), hp_m);
    chk({tag, "_dead"}, int'(dead), int'(hp_m == 0));
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_index"}, int'(bullet_index), 0);
    chk({tag, "_idle_done"}, int'(done), 0);
    @(negedge clk);
    chk({tag, "_still_idle"}, int'(busy), 0);
  endtask

  initial begin
    int w, pulses, bx, by;
    rst = 1'b1; start = 1'b0;
    set_player(50, 50, 16, 16, 1'b0);
    clear_slots();
    hp_m = HP_MAX;
    #23;
    chk("rst_hp", int'(hp), HP_MAX);
    chk("rst_dead", int'(dead), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_collide", int'(is_collide), 0);
    chk("rst_index", int'(bullet_index), 0);
    @(negedge clk); rst = 1'b0;

    run_scan("empty", -1, 1'b0);

    set_slot(3, 60, 60, 8, 8, 0);
    run_scan("white3", -1, 1'b0);

    clear_slots(); set_slot(5, 55, 55, 6, 6, 2);
    run_scan("blue_still", -1, 1'b0);
    player_moving = 1'b1;
    run_scan("blue_moving", -1, 1'b0);

    clear_slots(); set_player(50, 50, 16, 16, 1'b0);
    set_slot(0, 66, 50, 8, 8, 0);
    set_slot(1, 55, 55, 0, 4, 0);
    set_slot(2, 55, 55, 4, 0, 0);
    run_scan("edges", -1, 1'b0);
    clear_slots(); set_player(245, 245, 8, 8, 1'b0);
    set_slot(4, 250, 250, 10, 10, 0);
    run_scan("nowrap", -1, 1'b0);

    // Reset arriving while slot 2's hit is being applied must discard it.
    clear_slots(); set_player(50, 50, 16, 16, 1'b0);
    set_slot(2, 55, 55, 4, 4, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!is_collide && w < 20) begin @(negedge clk); w++; end
    chk("midhit_reached", int'(is_collide), 1);
    chk("midhit_index", int'(bullet_index), 2);
    rst = 1'b1; #1;
    chk("midhit_collide", int'(is_collide), 0);
    chk("midhit_hp", int'(hp), HP_MAX);
    chk("midhit_busy", int'(busy), 0);
    chk("midhit_index0", int'(bullet_index), 0);
    chk("midhit_done", int'(done), 0);
    @(negedge clk); rst = 1'b0;
    hp_m = HP_MAX;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || is_collide || busy) pulses++;
    end
    chk("midhit_stays_idle", pulses, 0);

    clear_slots(); set_slot(6, 60, 60, 3, 3, 1);
    run_scan("green_full", -1, 1'b0);

    clear_slots();
    for (int i = 0; i < 8; i++) set_slot(i, 55, 55, 4, 4, 0);
    run_scan("drain_a", -1, 1'b0);
    run_scan("drain_b", -1, 1'b0);
    clear_slots();
    for (int i = 0; i < 3; i++) set_slot(i, 55, 55, 4, 4, 0);
    run_scan("drain_c", -1, 1'b0);
    chk("drain_hp1", int'(hp), 1);
    clear_slots(); set_slot(0, 55, 55, 4, 4, 0); set_slot(1, 55, 55, 4, 4, 0);
    run_scan("to_zero", -1, 1'b0);
    chk("zero_dead", int'(dead), 1);
    clear_slots(); set_slot(0, 55, 55, 4, 4, 0);
    run_scan("hit_at_zero", -1, 1'b0);
    clear_slots(); set_slot(2, 55, 55, 4, 4, 1);
    run_scan("green_revive", -1, 1'b0);
    chk("revive_hp1", int'(hp), 1);

    clear_slots(); set_slot(1, 52, 52, 4, 4, 1); set_slot(7, 60, 60, 4, 4, 5);
    run_scan("busy_start", 3, 1'b1);

    for (int s = 0; s < 40; s++) begin
      set_player($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 24), $urandom_range(0, 24), 1'($urandom_range(0, 1)));
      clear_slots();
      for (int i = 0; i < 8; i++) begin
        bx = int'(player_pos[15:8]) + $urandom_range(0, 48) - 24;
        by = int'(player_pos[7:0]) + $urandom_range(0, 48) - 24;
        bx = (bx < 0) ? 0 : (bx > 255) ? 255 : bx;
        by = (by < 0) ? 0 : (by > 255) ? 255 : by;
        set_slot(i, bx, by, $urandom_range(0, 16), $urandom_range(0, 16),
                 $urandom_range(0, 7));
        b_ren[i] = ($urandom_range(0, 3) != 0);
      end
      run_scan("random", $urandom_range(0, 12), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
